// File: rtl/weight_loader_pkg.sv
// -----------------------------------------------------------------------------
// weight_loader_pkg
//   Shared types and constants for the weight-memory byte-stream loader.
//   - wl_state_e   : frame-parser state encoding
//   - SEL_*_DEFAULT: default header bytes selecting the L1 / L2 weight RAM
//   - MEM_L1/MEM_L2: index of each memory in the loader's internal arrays
//   - clogb2       : bit width needed to hold a value (also used by the layer
//                    to size its port-B read address)
// -----------------------------------------------------------------------------
package weight_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_DATA_HI = 3'd5,
        ST_DATA_LO = 3'd6
    } wl_state_e;

    localparam int         WEIGHT_DEPTH_DEFAULT = 8192;
    localparam logic [7:0] SEL_L1_DEFAULT       = 8'h01;
    localparam logic [7:0] SEL_L2_DEFAULT       = 8'h02;

    localparam int NUM_MEMS = 2;
    localparam int MEM_L1   = 0;
    localparam int MEM_L2   = 1;

    // Number of bits needed to represent 'value' (clogb2(8191) = 13).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : weight_loader_pkg

// File: rtl/weight_loader_if.sv
// -----------------------------------------------------------------------------
// weight_loader_if
//   Valid/ready byte stream from the host link deframer into the loader.
//   A byte transfers on a rising clock edge where in_valid && in_ready.
//   Signals:
//     in_valid : source has a byte on in_data
//     in_data  : stream byte
//     in_ready : sink accepts the byte this cycle
//   Modports:
//     master : byte source (deframer / testbench)
//     slave  : byte sink (weight_loader)
// -----------------------------------------------------------------------------
interface weight_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface : weight_loader_if

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//   Parses framed write commands from a byte stream and writes 16-bit words
//   into the port-A side of the L1 or L2 weight RAM.
//
//   Frame: SEL, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words sent as
//   two bytes each, high byte first. The address auto-increments and wraps
//   at WEIGHT_DEPTH.
//
//   Ports:
//     clk                    : clock, rising edge
//     rst                    : asynchronous reset, active low
//     in_if (slave)          : in_valid / in_data / in_ready byte stream
//     layer_busy             : layer is reading weights; holds off writes
//     weight_mem_Lx_wren     : 8 identical write strobes (one-cycle pulse)
//     weight_mem_Lx_wr_addr  : write address (zero outside a write pulse)
//     weight_mem_Lx_data_in  : write data    (zero outside a write pulse)
//     weight_mem_Lx_ena      : port-A enable, same as wren[0]
//     busy                   : frame in progress
//     done                   : one-cycle pulse when a frame completes
//     err                    : one-cycle pulse after an invalid header byte
// -----------------------------------------------------------------------------
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int         WEIGHT_DEPTH = WEIGHT_DEPTH_DEFAULT,
    parameter logic [7:0] SEL_L1       = SEL_L1_DEFAULT,
    parameter logic [7:0] SEL_L2       = SEL_L2_DEFAULT,
    localparam int        ADDR_W       = clogb2(WEIGHT_DEPTH - 1)
) (
    input  logic              clk,
    input  logic              rst,
    weight_loader_if.slave    in_if,
    input  logic              layer_busy,

    output logic [7:0]        weight_mem_L1_wren,
    output logic [ADDR_W-1:0] weight_mem_L1_wr_addr,
    output logic [15:0]       weight_mem_L1_data_in,
    output logic              weight_mem_L1_ena,

    output logic [7:0]        weight_mem_L2_wren,
    output logic [ADDR_W-1:0] weight_mem_L2_wr_addr,
    output logic [15:0]       weight_mem_L2_data_in,
    output logic              weight_mem_L2_ena,

    output logic              busy,
    output logic              done,
    output logic              err
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    wl_state_e             state_q, state_d;
    logic                  sel_mem_q, sel_mem_d;   // 0 = L1, 1 = L2
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;         // next word's address
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           cnt_q, cnt_d;           // words still to write
    logic [7:0]            data_hi_q, data_hi_d;

    // Shared write register for both memories; the strobe bits pick the target.
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [NUM_MEMS-1:0]   wr_stb_q, wr_stb_d;

    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  is_sel;
    logic [15:0]           cnt_full;
    logic [ADDR_W-1:0]     addr_inc;

    // Handshake: the only stall point is the byte that triggers a RAM write.
    // in_ready is gated by rst so it is low for the whole reset period.
    always_comb begin
        in_if.in_ready = rst && !((state_q == ST_DATA_LO) && layer_busy);
    end

    assign accept   = in_if.in_valid && in_if.in_ready;
    assign is_sel   = (in_if.in_data == SEL_L1) || (in_if.in_data == SEL_L2);
    assign cnt_full = {cnt_hi_q, in_if.in_data};
    assign addr_inc = (addr_q == ADDR_W'(WEIGHT_DEPTH - 1)) ? '0
                                                           : addr_q + ADDR_W'(1);

    // -------------------------------------------------------------------------
    // State register (plus datapath registers sharing the same reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sel_mem_q <= 1'b0;
            addr_hi_q <= '0;
            addr_q    <= '0;
            cnt_hi_q  <= '0;
            cnt_q     <= '0;
            data_hi_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_mem_q <= sel_mem_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            cnt_hi_q  <= cnt_hi_d;
            cnt_q     <= cnt_d;
            data_hi_q <= data_hi_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: every transition happens on an accepted byte
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                ST_IDLE:    state_d = is_sel ? ST_ADDR_HI : ST_IDLE;
                ST_ADDR_HI: state_d = ST_ADDR_LO;
                ST_ADDR_LO: state_d = ST_CNT_HI;
                ST_CNT_HI:  state_d = ST_CNT_LO;
                ST_CNT_LO:  state_d = (cnt_full == 16'd0) ? ST_IDLE : ST_DATA_HI;
                ST_DATA_HI: state_d = ST_DATA_LO;
                ST_DATA_LO: state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_DATA_HI;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath / registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        sel_mem_d = sel_mem_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        cnt_hi_d  = cnt_hi_q;
        cnt_d     = cnt_q;
        data_hi_d = data_hi_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = '0;        // strobes are single-cycle pulses
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_if.in_data == SEL_L1) begin
                        sel_mem_d = 1'b0;
                    end else if (in_if.in_data == SEL_L2) begin
                        sel_mem_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_ADDR_HI: addr_hi_d = in_if.in_data;
                // Upper address bits beyond the RAM depth are discarded.
                ST_ADDR_LO: addr_d = ADDR_W'({addr_hi_q, in_if.in_data});
                ST_CNT_HI:  cnt_hi_d = in_if.in_data;
                ST_CNT_LO: begin
                    cnt_d  = cnt_full;
                    done_d = (cnt_full == 16'd0);
                end
                ST_DATA_HI: data_hi_d = in_if.in_data;
                ST_DATA_LO: begin
                    wr_addr_d = addr_q;
                    wr_data_d = {data_hi_q, in_if.in_data};
                    wr_stb_d[sel_mem_q] = 1'b1;
                    addr_d    = addr_inc;
                    cnt_d     = cnt_q - 16'd1;
                    // done lands in the same cycle as the final write pulse.
                    done_d    = (cnt_q == 16'd1);
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: per-memory groups derived from the shared write register.
    // Address/data are forced to zero outside a pulse so the memory that is
    // not being written never sees activity.
    // -------------------------------------------------------------------------
    logic [7:0]        mem_wren [NUM_MEMS];
    logic [ADDR_W-1:0] mem_addr [NUM_MEMS];
    logic [15:0]       mem_data [NUM_MEMS];
    logic              mem_ena  [NUM_MEMS];

    for (genvar gi = 0; gi < NUM_MEMS; gi++) begin : g_mem
        assign mem_wren[gi] = {8{wr_stb_q[gi]}};
        assign mem_ena[gi]  = wr_stb_q[gi];
        assign mem_addr[gi] = wr_stb_q[gi] ? wr_addr_q : '0;
        assign mem_data[gi] = wr_stb_q[gi] ? wr_data_q : '0;
    end

    always_comb begin
        weight_mem_L1_wren    = mem_wren[MEM_L1];
        weight_mem_L1_wr_addr = mem_addr[MEM_L1];
        weight_mem_L1_data_in = mem_data[MEM_L1];
        weight_mem_L1_ena     = mem_ena[MEM_L1];

        weight_mem_L2_wren    = mem_wren[MEM_L2];
        weight_mem_L2_wr_addr = mem_addr[MEM_L2];
        weight_mem_L2_data_in = mem_data[MEM_L2];
        weight_mem_L2_ena     = mem_ena[MEM_L2];

        busy = (state_q != ST_IDLE);
        done = done_q;
        err  = err_q;
    end

endmodule : weight_loader

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//   Drives framed byte streams into weight_loader and checks the RAM writes,
//   done/err pulses and handshake behaviour against a frame-level model:
//   word i of a frame goes to memory SEL at (ADDR + i) mod DEPTH.
// -----------------------------------------------------------------------------
module tb_weight_loader;

    localparam int DEPTH  = 8192;
    localparam int ADDR_W = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic layer_busy = 1'b0;

    logic [7:0]        l1_wren, l2_wren;
    logic [ADDR_W-1:0] l1_addr, l2_addr;
    logic [15:0]       l1_data, l2_data;
    logic              l1_ena, l2_ena;
    logic              busy, done, err;

    weight_loader_if u_if ();

    weight_loader #(
        .WEIGHT_DEPTH (DEPTH),
        .SEL_L1       (8'h01),
        .SEL_L2       (8'h02)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_if                 (u_if),
        .layer_busy            (layer_busy),
        .weight_mem_L1_wren    (l1_wren),
        .weight_mem_L1_wr_addr (l1_addr),
        .weight_mem_L1_data_in (l1_data),
        .weight_mem_L1_ena     (l1_ena),
        .weight_mem_L2_wren    (l2_wren),
        .weight_mem_L2_wr_addr (l2_addr),
        .weight_mem_L2_data_in (l2_data),
        .weight_mem_L2_ena     (l2_ena),
        .busy                  (busy),
        .done                  (done),
        .err                   (err)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- state
    typedef struct {
        int mem;    // 1 = L1, 2 = L2
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  done_cyc_q[$];
    int  err_cyc_q[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int viol_overlap = 0;
    int viol_strobe = 0;
    int viol_busy_done = 0;
    int l1_act = 0;
    int l2_act = 0;
    int last_accept_cyc = 0;
    bit rand_busy_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        wr_t w;
        if (l1_wren != 8'h00) begin
            w.mem = 1; w.addr = int'(l1_addr); w.data = int'(l1_data); w.cyc = cyc;
            obs_q.push_back(w);
        end
        if (l2_wren != 8'h00) begin
            w.mem = 2; w.addr = int'(l2_addr); w.data = int'(l2_data); w.cyc = cyc;
            obs_q.push_back(w);
        end
        if (l1_wren != 8'h00 && l2_wren != 8'h00) viol_overlap++;
        if ((l1_wren != 8'h00 && l1_wren != 8'hFF) || (l1_ena !== l1_wren[0]) ||
            (l2_wren != 8'h00 && l2_wren != 8'hFF) || (l2_ena !== l2_wren[0]))
            viol_strobe++;
        if (l1_wren != 8'h00 || l1_addr != '0 || l1_data != 16'h0 || l1_ena) l1_act++;
        if (l2_wren != 8'h00 || l2_addr != '0 || l2_data != 16'h0 || l2_ena) l2_act++;
        if (done) done_cyc_q.push_back(cyc);
        if (done && busy) viol_busy_done++;
        if (err) err_cyc_q.push_back(cyc);
    end

    // Random layer_busy activity, only while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_busy_en) layer_busy = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- helpers
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        done_cyc_q.delete();
        err_cyc_q.delete();
    endtask

    // Present one byte and hold it until the DUT takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        u_if.in_valid = 1'b1;
        u_if.in_data  = b;
        while (1) begin
            @(negedge clk);
            if (u_if.in_ready === 1'b1) break;
            waited++;
            if (waited > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: in_ready=%b for byte %02h, required 1 within 500 cycles",
                         u_if.in_ready, b);
                break;
            end
        end
        @(posedge clk);
        #1;
        last_accept_cyc = cyc;
        u_if.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int addr, input int cnt, input int words[$]);
        $display("frame sel=%02h addr=%04h cnt=%0d", sel[7:0], addr[15:0], cnt);
        send_byte(8'(sel));
        send_byte(8'(addr >> 8));
        send_byte(8'(addr));
        send_byte(8'(cnt >> 8));
        send_byte(8'(cnt));
        for (int i = 0; i < cnt; i++) begin
            send_byte(8'(words[i] >> 8));
            send_byte(8'(words[i]));
        end
    endtask

    // Reference model: the writes a frame should produce.
    task automatic model_frame(input int mem, input int addr, input int cnt, input int words[$]);
        wr_t w;
        for (int i = 0; i < cnt; i++) begin
            w.mem  = mem;
            w.addr = (addr + i) % DEPTH;
            w.data = words[i] & 16'hFFFF;
            w.cyc  = 0;
            exp_q.push_back(w);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;
        rst = 1'b0;
        wait_cycles(3);
        vectors++;
        if ({l1_wren, l1_addr, l1_data, l1_ena, l2_wren, l2_addr, l2_data, l2_ena, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got L1 %h/%h/%h/%b L2 %h/%h/%h/%b busy %b done %b err %b, required all 0",
                     l1_wren, l1_addr, l1_data, l1_ena, l2_wren, l2_addr, l2_data, l2_ena, busy, done, err);
        end
        vectors++;
        if (u_if.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 0", u_if.in_ready);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (u_if.in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready %b busy %b, required 1 and 0", u_if.in_ready, busy);
        end
    endtask

    task automatic test_l1_frame();
        int words[$];
        int l2_before;
        clear_obs();
        l2_before = l2_act;
        words = '{16'hABCD, 16'h1234};
        model_frame(1, 16'h0010, 2, words);
        send_frame(8'h01, 16'h0010, 2, words);
        wait_cycles(3);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL l1_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].mem !== exp_q[i].mem || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL l1_write%0d: got mem%0d addr %h data %h, required mem%0d addr %h data %h", i,
                         obs_q[i].mem, obs_q[i].addr, obs_q[i].data, exp_q[i].mem, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (l2_act !== l2_before) begin
            miscompares++;
            $display("FAIL l1_l2_quiet: got %0d active L2 cycles, required 0", l2_act - l2_before);
        end
        vectors++;
        if (done_cyc_q.size() !== 1 || obs_q.size() < 2 || done_cyc_q[0] !== obs_q[obs_q.size()-1].cyc) begin
            miscompares++;
            $display("FAIL l1_done_timing: got %0d done pulses (first at cycle %0d), required 1 with the last write",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL l1_busy_after: got %b, required 0", busy);
        end
    endtask

    task automatic test_wrap();
        int words[$];
        int l1_before;
        clear_obs();
        l1_before = l1_act;
        for (int i = 0; i < 3; i++) words.push_back(int'($urandom_range(0, 65535)));
        model_frame(2, 16'h1FFF, 3, words);
        send_frame(8'h02, 16'h1FFF, 3, words);
        wait_cycles(3);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL wrap_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].mem !== exp_q[i].mem || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL wrap_write%0d: got mem%0d addr %h data %h, required mem%0d addr %h data %h", i,
                         obs_q[i].mem, obs_q[i].addr, obs_q[i].data, exp_q[i].mem, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (l1_act !== l1_before) begin
            miscompares++;
            $display("FAIL wrap_l1_quiet: got %0d active L1 cycles, required 0", l1_act - l1_before);
        end
    endtask

    task automatic test_bad_header();
        int words[$];
        int addr;
        clear_obs();
        $display("bad header 07");
        send_byte(8'h07);
        wait_cycles(2);
        vectors++;
        if (err_cyc_q.size() !== 1 || err_cyc_q[0] !== last_accept_cyc) begin
            miscompares++;
            $display("FAIL bad_hdr_err: got %0d err pulses (first at cycle %0d), required 1 at cycle %0d",
                     err_cyc_q.size(), (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, last_accept_cyc);
        end
        vectors++;
        if (obs_q.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_hdr_quiet: got %0d writes busy %b, required 0 writes busy 0", obs_q.size(), busy);
        end
        addr = int'($urandom_range(0, 65535));
        words = '{int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))};
        model_frame(1, addr, 2, words);
        send_frame(8'h01, addr, 2, words);
        wait_cycles(3);
        vectors++;
        if (obs_q.size() !== exp_q.size() || err_cyc_q.size() !== 1) begin
            miscompares++;
            $display("FAIL bad_hdr_follow_count: got %0d writes %0d errs, required %0d writes 1 err",
                     obs_q.size(), err_cyc_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].mem !== exp_q[i].mem || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL bad_hdr_follow_write%0d: got mem%0d addr %h data %h, required mem%0d addr %h data %h", i,
                         obs_q[i].mem, obs_q[i].addr, obs_q[i].data, exp_q[i].mem, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_zero_count();
        int words[$];
        clear_obs();
        send_frame(8'h01, 16'h0100, 0, words);
        wait_cycles(3);
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL zero_cnt_writes: got %0d, required 0", obs_q.size());
        end
        vectors++;
        if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_accept_cyc) begin
            miscompares++;
            $display("FAIL zero_cnt_done: got %0d pulses (first at cycle %0d), required 1 at cycle %0d",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, last_accept_cyc);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_cnt_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_stall();
        int drop_cyc;
        clear_obs();
        layer_busy = 1'b1;
        $display("stall frame sel=01 addr=0aaa cnt=1 data=5aa5");
        // Header and high byte must pass even while the layer is busy.
        send_byte(8'h01); send_byte(8'h0A); send_byte(8'hAA);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h5A);
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (u_if.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_ready cycle %0d: got %b, required 0", i, u_if.in_ready);
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL stall_no_write: got %0d writes, required 0", obs_q.size());
        end
        layer_busy = 1'b0;
        drop_cyc = cyc;
        @(negedge clk);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        wait_cycles(2);
        vectors++;
        if (obs_q.size() !== 1) begin
            miscompares++;
            $display("FAIL stall_write_count: got %0d, required 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0].mem !== 1 || obs_q[0].addr !== 32'h0AAA || obs_q[0].data !== 32'h5AA5 || obs_q[0].cyc !== drop_cyc + 1) begin
                miscompares++;
                $display("FAIL stall_write: got mem%0d addr %h data %h cycle %0d, required mem1 addr 0aaa data 5aa5 cycle %0d",
                         obs_q[0].mem, obs_q[0].addr, obs_q[0].data, obs_q[0].cyc, drop_cyc + 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int words[$];
        clear_obs();
        $display("frame sel=01 addr=0200 cnt=4 (reset after first word)");
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22);
        vectors++;
        if (l1_wren !== 8'hFF) begin
            miscompares++;
            $display("FAIL midrst_pre_write: got wren %h, required ff", l1_wren);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({l1_wren, l1_addr, l1_data, l1_ena, l2_wren, l2_addr, l2_data, l2_ena, busy, done, err, u_if.in_ready} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got L1 %h/%h/%h/%b busy %b in_ready %b, required all 0",
                     l1_wren, l1_addr, l1_data, l1_ena, busy, u_if.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (u_if.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_release_ready: got %b, required 1", u_if.in_ready);
        end
        words = '{16'hBEEF};
        model_frame(2, 16'h0300, 1, words);
        send_frame(8'h02, 16'h0300, 1, words);
        wait_cycles(3);
        vectors++;
        if (obs_q.size() !== 1) begin
            miscompares++;
            $display("FAIL midrst_fresh_count: got %0d writes, required 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0].mem !== exp_q[0].mem || obs_q[0].addr !== exp_q[0].addr || obs_q[0].data !== exp_q[0].data) begin
                miscompares++;
                $display("FAIL midrst_fresh_write: got mem%0d addr %h data %h, required mem%0d addr %h data %h",
                         obs_q[0].mem, obs_q[0].addr, obs_q[0].data, exp_q[0].mem, exp_q[0].addr, exp_q[0].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w1[$];
        int w2[$];
        int gaps[4];
        clear_obs();
        gaps = '{2, 2, 7, 2};
        for (int i = 0; i < 3; i++) w1.push_back(int'($urandom_range(0, 65535)));
        for (int i = 0; i < 2; i++) w2.push_back(int'($urandom_range(0, 65535)));
        model_frame(1, 16'h0040, 3, w1);
        model_frame(2, 16'h0800, 2, w2);
        send_frame(8'h01, 16'h0040, 3, w1);
        send_frame(8'h02, 16'h0800, 2, w2);
        wait_cycles(3);
        vectors++;
        if (obs_q.size() !== 5 || done_cyc_q.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_counts: got %0d writes %0d done, required 5 writes 2 done", obs_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].mem !== exp_q[i].mem || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL b2b_write%0d: got mem%0d addr %h data %h, required mem%0d addr %h data %h", i,
                         obs_q[i].mem, obs_q[i].addr, obs_q[i].data, exp_q[i].mem, exp_q[i].addr, exp_q[i].data);
            end
        end
        for (int i = 0; i < 4 && i + 1 < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i+1].cyc - obs_q[i].cyc !== gaps[i]) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, obs_q[i+1].cyc - obs_q[i].cyc, gaps[i]);
            end
        end
    endtask

    task automatic test_random();
        int exp_done;
        int exp_err;
        clear_obs();
        exp_done = 0;
        exp_err  = 0;
        rand_busy_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                logic [7:0] bad;
                bad = 8'($urandom_range(3, 255));
                $display("bad header %02h", bad);
                send_byte(bad);
                exp_err++;
            end else begin
                int mem;
                int addr;
                int cnt;
                int words[$];
                mem  = int'($urandom_range(1, 2));
                addr = int'($urandom_range(0, 65535));
                cnt  = int'($urandom_range(0, 6));
                for (int i = 0; i < cnt; i++) words.push_back(int'($urandom_range(0, 65535)));
                model_frame(mem, addr, cnt, words);
                send_frame(mem, addr, cnt, words);
                exp_done++;
            end
            wait_cycles(int'($urandom_range(0, 2)));
        end
        rand_busy_en = 1'b0;
        layer_busy   = 1'b0;
        wait_cycles(4);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].mem !== exp_q[i].mem || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL rand_write%0d: got mem%0d addr %h data %h, required mem%0d addr %h data %h", i,
                         obs_q[i].mem, obs_q[i].addr, obs_q[i].data, exp_q[i].mem, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (done_cyc_q.size() !== exp_done || err_cyc_q.size() !== exp_err) begin
            miscompares++;
            $display("FAIL rand_pulses: got %0d done %0d err, required %0d done %0d err",
                     done_cyc_q.size(), err_cyc_q.size(), exp_done, exp_err);
        end
    endtask

    task automatic test_invariants();
        vectors++;
        if (viol_overlap !== 0) begin
            miscompares++;
            $display("FAIL inv_overlap: got %0d cycles with both memories strobed, required 0", viol_overlap);
        end
        vectors++;
        if (viol_strobe !== 0) begin
            miscompares++;
            $display("FAIL inv_strobe: got %0d cycles with wren/ena inconsistent, required 0", viol_strobe);
        end
        vectors++;
        if (viol_busy_done !== 0) begin
            miscompares++;
            $display("FAIL inv_busy_done: got %0d cycles with done while busy, required 0", viol_busy_done);
        end
    endtask

    initial begin
        test_reset();
        test_l1_frame();
        test_wrap();
        test_bad_header();
        test_zero_count();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_weight_loader
